// File: rtl/spec_dpram_readout_pkg.sv
// Shared constants and types for the power-spectrum buffer
// readout path (FSM encoding is shared with the accumulate side).
package spec_dpram_readout_pkg;

  localparam int SPEC_ADDR_W     = 14;
  localparam int SPEC_POINT_BITS = 10;
  localparam int SPEC_MAX_BINS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } spec_state_e;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [31:0] data;
  } spec_word_t;

  function automatic logic [4:0] spec_clamp_bins(
    input logic [4:0] nb,
    input int         max_bins
  );
    return (int'(nb) > max_bins) ? 5'(max_bins) : nb;
  endfunction

endpackage

// File: rtl/spec_dpram_readout_fifo.sv
// Small synchronous skid FIFO: absorbs RAM read latency
// under backpressure. Push on full is honoured only with a pop.
module spec_skid_fifo
  import spec_dpram_readout_pkg::*;
#(
  parameter  int Width = 34,
  parameter  int Depth = 4,
  localparam int CntW  = $clog2(Depth + 1),
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wp;
  logic [PtrW-1:0]  rp;
  logic             wr;
  logic             rd;

  function automatic logic [PtrW-1:0] nxt(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CntW'(Depth));
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (rd) begin
        rp <= nxt(rp);
      end
      unique case (1'b1)
        (wr && !rd): count <= count + 1'b1;
        (rd && !wr): count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spec_dpram_readout.sv
// Streams the accumulated spectrum buffer out of DPRAM port B
// with credit-limited reads into a skid FIFO and valid/ready output.
module spec_dpram_readout
  import spec_dpram_readout_pkg::*;
#(
  parameter int AddrBits  = SPEC_ADDR_W,
  parameter int PointBits = SPEC_POINT_BITS,
  parameter int MaxBins   = SPEC_MAX_BINS,
  parameter int RdLatency = 1,
  parameter int FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [4:0]          nof_bins_i,
  output logic [AddrBits-1:0] rd_addr_o,
  input  logic [31:0]         rd_data_i,
  output logic [15:0]         y0_o,
  output logic [15:0]         y0z_o,
  output logic                data_valid_o,
  input  logic                ready_i,
  output logic                sof_o,
  output logic                eof_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam int SpanW = AddrBits + 1;

  spec_state_e          state;
  logic [AddrBits-1:0]  rd_addr;
  logic [AddrBits-1:0]  last_addr;
  logic [AddrBits-1:0]  last_nxt;
  logic [4:0]           nb_c;
  logic [SpanW-1:0]     span;
  logic [RdLatency-1:0] pipe_v;
  logic [RdLatency-1:0] pipe_sof;
  logic [RdLatency-1:0] pipe_eof;
  logic [CntW-1:0]      fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 issue;
  logic                 pop;
  spec_word_t           wr_word;
  spec_word_t           head;

  always_comb begin
    nb_c     = spec_clamp_bins(nof_bins_i, MaxBins);
    span     = SpanW'(nb_c) << PointBits;
    last_nxt = AddrBits'(span - SpanW'(1));
  end

  // Credit: every outstanding read already owns a FIFO slot.
  assign issue = (state == ST_READ) && !fifo_full
               && ($countones(pipe_v) + int'(fifo_cnt) < FifoDepth);
  assign pop   = !fifo_empty && ready_i;

  assign wr_word = '{
    sof:  pipe_sof[RdLatency-1],
    eof:  pipe_eof[RdLatency-1],
    data: rd_data_i
  };

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_v   <= '0;
      pipe_sof <= '0;
      pipe_eof <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_sof[0] <= issue && (rd_addr == '0);
      pipe_eof[0] <= issue && (rd_addr == last_addr);
      for (int i = 1; i < RdLatency; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_sof[i] <= pipe_sof[i-1];
        pipe_eof[i] <= pipe_eof[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      last_addr   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (nof_bins_i == '0) begin
              state  <= ST_FIN;
              done_o <= 1'b1;
            end else begin
              state     <= ST_READ;
              rd_addr   <= '0;
              last_addr <= last_nxt;
              busy_o    <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            if (rd_addr == last_addr) begin
              state <= ST_DRAIN;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head.eof) begin
            state       <= ST_FIN;
            done_o      <= 1'b1;
            frame_cnt_o <= frame_cnt_o + 1'b1;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spec_skid_fifo #(
    .Width ($bits(spec_word_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (pipe_v[RdLatency-1]),
    .din   (wr_word),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rd_addr_o    = rd_addr;
  assign data_valid_o = !fifo_empty;
  assign y0_o         = head.data[15:0];
  assign y0z_o        = head.data[31:16];
  assign sof_o        = data_valid_o && head.sof;
  assign eof_o        = data_valid_o && head.eof;

endmodule

// File: tb/tb_spec_dpram_readout.sv
// Bench for spec_dpram_readout: three instances with read
// latency 1..3, each fed by a behavioural RAM returning base+addr.
module tb_spec_dpram_readout;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start [N];
  logic [4:0]  nb    [N];
  logic [13:0] rd_addr [N];
  logic [15:0] y0    [N];
  logic [15:0] y0z   [N];
  logic        valid [N];
  logic        ready [N];
  logic        sof   [N];
  logic        eof   [N];
  logic        busy  [N];
  logic        done  [N];
  logic [15:0] fcnt  [N];

  logic [31:0] ram_base = '0;
  logic [33:0] capq [N][$];
  int          stray  = 0;
  int          errors = 0;
  int          checks = 0;

  logic [13:0] sa_addr, sb_addr;
  logic [31:0] sa_head, sb_head;
  logic        sb_valid;

  for (genvar g = 0; g < N; g++) begin : g_lat
    localparam int L = g + 1;
    logic [13:0] q [L];
    logic [31:0] rdd;
    int          ovf = 0;
    always @(posedge clk) begin
      q[0] <= rd_addr[g];
      for (int k = 1; k < L; k++) q[k] <= q[k-1];
      if (u_dut.u_fifo.push && u_dut.u_fifo.full
          && !u_dut.u_fifo.pop)
        ovf <= ovf + 1;
    end
    assign rdd = ram_base + 32'(q[L-1]);
    spec_dpram_readout #(.RdLatency(L)) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start[g]),
      .nof_bins_i   (nb[g]),
      .rd_addr_o    (rd_addr[g]),
      .rd_data_i    (rdd),
      .y0_o         (y0[g]),
      .y0z_o        (y0z[g]),
      .data_valid_o (valid[g]),
      .ready_i      (ready[g]),
      .sof_o        (sof[g]),
      .eof_o        (eof[g]),
      .busy_o       (busy[g]),
      .done_o       (done[g]),
      .frame_cnt_o  (fcnt[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (valid[k] && ready[k])
        capq[k].push_back({eof[k], sof[k], y0z[k], y0[k]});
      if (!valid[k] && (sof[k] || eof[k]))
        stray++;
    end
  end

  // Reference stream: n contiguous words base+k, sof on 0, eof on n-1.
  function automatic int first_bad(
    input int i, input int n, input logic [31:0] base);
    logic [33:0] e;
    if (capq[i].size() != n) return -2;
    for (int k = 0; k < n; k++) begin
      e = {(k == n - 1), (k == 0), base + 32'(k)};
      if (capq[i][k] !== e) return k;
    end
    return -1;
  endfunction

  task automatic run_frame(
    input int i, input logic [4:0] n, input bit rnd,
    input int stall_at, input int restart_at, input int limit,
    output int first, output int donec);
    first = -1;
    donec = -1;
    @(posedge clk); #1;
    for (int c = 0; c < limit; c++) begin
      start[i] = (c == 0) || (c == restart_at);
      nb[i]    = (c == 0) ? n : 5'd2;
      if (c >= stall_at && c < stall_at + 20) ready[i] = 1'b0;
      else ready[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (valid[i] && first < 0) first = c;
      if (c == stall_at + 5) begin
        sa_addr = rd_addr[i];
        sa_head = {y0z[i], y0[i]};
      end
      if (c == stall_at + 19) begin
        sb_addr  = rd_addr[i];
        sb_head  = {y0z[i], y0[i]};
        sb_valid = valid[i];
      end
      if (done[i]) begin
        donec = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start[i] = 1'b0;
    ready[i] = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs [9];
    string nm [9] = '{"rd_addr", "y0", "y0z", "valid", "sof",
                      "eof", "busy", "done", "frame_cnt"};
    @(negedge clk);
    obs = '{16'(rd_addr[0]), y0[0], y0z[0], 16'(valid[0]),
            16'(sof[0]), 16'(eof[0]), 16'(busy[0]),
            16'(done[0]), fcnt[0]};
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset_%s: got %0h want 0", nm[k], obs[k]);
      end
    end
  endtask

  task automatic test_single_bin();
    int first, donec, bad;
    ram_base = 32'd0;
    capq[0].delete();
    run_frame(0, 5'd1, 1'b0, -1000, -1, 3000, first, donec);
    checks++;
    if (first !== 3) begin
      errors++;
      $display("FAIL latency: got %0d want 3", first);
    end
    checks++;
    if (donec !== 1027) begin
      errors++;
      $display("FAIL done_cycle: got %0d want 1027", donec);
    end
    bad = first_bad(0, 1024, ram_base);
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("FAIL stream_1bin: bad=%0d words=%0d want 1024",
               bad, capq[0].size());
    end
    checks++;
    if (fcnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL frame_cnt_1: got %0d want 1", fcnt[0]);
    end
    @(negedge clk);
    checks++;
    if ({done[0], busy[0]} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b want 0 0",
               done[0], busy[0]);
    end
  endtask

  task automatic test_random_ready();
    int first, donec, bad;
    ram_base = 32'hABCD0000;
    capq[0].delete();
    run_frame(0, 5'd16, 1'b1, -1000, -1, 70000, first, donec);
    bad = first_bad(0, 16384, ram_base);
    checks++;
    if (bad !== -1 || donec < 0) begin
      errors++;
      $display("FAIL stream_16bin_rand: bad=%0d words=%0d done=%0d",
               bad, capq[0].size(), donec);
    end
    checks++;
    if (capq[0].size() < 6 ||
        capq[0][5][31:0] !== 32'hABCD0005) begin
      errors++;
      $display("FAIL halves: got %0h want abcd0005",
               capq[0].size() < 6 ? 34'h0 : capq[0][5]);
    end
    checks++;
    if (fcnt[0] !== 16'd2) begin
      errors++;
      $display("FAIL frame_cnt_2: got %0d want 2", fcnt[0]);
    end
  endtask

  task automatic test_stall();
    int first, donec, bad;
    ram_base = 32'hABCD0000;
    for (int i = 0; i < N; i++) begin
      capq[i].delete();
      run_frame(i, 5'd1, 1'b0, 100, -1, 3000, first, donec);
      checks++;
      if (first !== 3 + i) begin
        errors++;
        $display("FAIL latency_L%0d: got %0d want %0d",
                 i + 1, first, 3 + i);
      end
      checks++;
      if (sa_addr !== sb_addr) begin
        errors++;
        $display("FAIL addr_stall_L%0d: got %0d then %0d want equal",
                 i + 1, sa_addr, sb_addr);
      end
      checks++;
      if (sa_head !== sb_head || sb_valid !== 1'b1) begin
        errors++;
        $display("FAIL head_held_L%0d: got %0h/%0h v=%b want equal v=1",
                 i + 1, sa_head, sb_head, sb_valid);
      end
      checks++;
      if (int'(sb_addr) !== int'(sb_head - ram_base) + 4) begin
        errors++;
        $display("FAIL credit_L%0d: got addr %0d want %0d",
                 i + 1, sb_addr, int'(sb_head - ram_base) + 4);
      end
      bad = first_bad(i, 1024, ram_base);
      checks++;
      if (bad !== -1 || donec < 0) begin
        errors++;
        $display("FAIL stream_stall_L%0d: bad=%0d words=%0d done=%0d",
                 i + 1, bad, capq[i].size(), donec);
      end
    end
  endtask

  task automatic test_zero_bins();
    int first, donec;
    logic [15:0] fc0;
    fc0 = fcnt[0];
    capq[0].delete();
    run_frame(0, 5'd0, 1'b0, -1000, -1, 20, first, donec);
    checks++;
    if (donec !== 1) begin
      errors++;
      $display("FAIL zero_done: got %0d want 1", donec);
    end
    checks++;
    if (first !== -1 || capq[0].size() !== 0) begin
      errors++;
      $display("FAIL zero_nodata: first=%0d words=%0d want -1 0",
               first, capq[0].size());
    end
    checks++;
    if (fcnt[0] !== fc0) begin
      errors++;
      $display("FAIL zero_cnt: got %0d want %0d", fcnt[0], fc0);
    end
  endtask

  task automatic test_clamp();
    int first, donec, bad;
    ram_base = 32'h12340000;
    capq[0].delete();
    run_frame(0, 5'd20, 1'b0, -1000, -1, 20000, first, donec);
    bad = first_bad(0, 16384, ram_base);
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("FAIL clamp_stream: bad=%0d words=%0d want 16384",
               bad, capq[0].size());
    end
    checks++;
    if (donec !== 16387) begin
      errors++;
      $display("FAIL clamp_done: got %0d want 16387", donec);
    end
  endtask

  task automatic test_restart_ignored();
    int first, donec, bad;
    ram_base = 32'hABCD0000;
    capq[0].delete();
    run_frame(0, 5'd1, 1'b0, -1000, 50, 3000, first, donec);
    bad = first_bad(0, 1024, ram_base);
    checks++;
    if (bad !== -1 || donec !== 1027) begin
      errors++;
      $display("FAIL restart: bad=%0d words=%0d done=%0d want 1027",
               bad, capq[0].size(), donec);
    end
  endtask

  task automatic test_reset_mid();
    int first, donec, bad;
    bit found;
    logic [15:0] obs [9];
    ram_base = 32'hABCD0000;
    @(posedge clk); #1;
    start[0] = 1'b1;
    nb[0]    = 5'd1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (valid[0] && y0[0] == 16'd500) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_word500: got none want word 500");
    end
    #1 rst_n = 1'b0;
    #1;
    obs = '{16'(rd_addr[0]), y0[0], y0z[0], 16'(valid[0]),
            16'(sof[0]), 16'(eof[0]), 16'(busy[0]),
            16'(done[0]), fcnt[0]};
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (obs[k] !== 16'd0) begin
        errors++;
        $display("FAIL midreset_out%0d: got %0h want 0", k, obs[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    found = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done[0] || busy[0] || valid[0]) found = 1'b1;
    end
    checks++;
    if (found) begin
      errors++;
      $display("FAIL abort_idle: got activity want idle");
    end
    capq[0].delete();
    run_frame(0, 5'd1, 1'b0, -1000, -1, 3000, first, donec);
    bad = first_bad(0, 1024, ram_base);
    checks++;
    if (bad !== -1 || first !== 3) begin
      errors++;
      $display("FAIL after_reset: bad=%0d first=%0d want -1 3",
               bad, first);
    end
    checks++;
    if (fcnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL after_reset_cnt: got %0d want 1", fcnt[0]);
    end
  endtask

  task automatic test_integrity();
    int ovf [N];
    ovf = '{g_lat[0].ovf, g_lat[1].ovf, g_lat[2].ovf};
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ovf[i] !== 0) begin
        errors++;
        $display("FAIL overflow_L%0d: got %0d want 0", i + 1, ovf[i]);
      end
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL stray_flags: got %0d want 0", stray);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0;
      nb[k]    = 5'd0;
      ready[k] = 1'b1;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_single_bin();
    test_random_ready();
    test_stall();
    test_zero_bins();
    test_clamp();
    test_restart_ignored();
    test_reset_mid();
    test_integrity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spec_dpram_readout.md
Name: spec_dpram_readout

Overview:
- Reader end of the accumulated power-spectrum buffer (32-bit words, 16 range bins x 1024 points, 14-bit address).
- After accumulation, post-processing and peak detection finish, the block streams the buffer out to the signal output pair (y0 = low half, y0z = high half).
- Output uses a valid/ready handshake.
- Absorbs the fixed RAM read latency with a credit-controlled skid FIFO, so backpressure never loses or duplicates a word.

Parameters:
- AddrBits, 14, DPRAM address width.
- PointBits, 10, log2 of points per range bin (1024).
- MaxBins, 16, maximum range bins per frame.
- RdLatency, 1, DPRAM port-B cycles from address to doutb; legal 1..3.
- FifoDepth, 4, skid FIFO entries; must be >= RdLatency+1.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a frame readout.
- nof_bins_i  in  5  range bins to read; sampled at accepted start.
- rd_addr_o  out  AddrBits  DPRAM port-B read address.
- rd_data_i  in  32  DPRAM port-B read data.
- y0_o  out  16  rd word [15:0].
- y0z_o  out  16  rd word [31:16].
- data_valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts word.
- sof_o  out  1  qualifies first word of frame (with valid).
- eof_o  out  1  qualifies last word of frame (with valid).
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse, frame complete.
- frame_cnt_o  out  16  completed frames, wraps at 65535->0.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, in-flight pipe cleared. Reset mid-frame aborts the frame; no done_o is produced.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE -> READ on start_i when nof_bins_i in 1..16:
  - latch last_addr = nof_bins*1024-1; values >16 clamp to 16.
  - rd_addr_o <= 0; busy_o <= 1 next cycle.
- IDLE with start_i and nof_bins_i = 0: FIN directly. done_o pulses; frame_cnt_o does not increment; no data.
- start_i while busy_o = 1 is ignored.
- Issue rule (READ): a read is issued in a cycle when inflight + fifo_count < FifoDepth.
  - Issued address is rd_addr_o; it advances by 1 on each issue.
  - inflight is a RdLatency-deep valid shift register; its tail pushes rd_data_i into the FIFO.
- Last issue (address = last_addr): READ -> DRAIN; rd_addr_o holds last_addr.
- Address order: bin-major, contiguous 0..last_addr (address = bin*1024 + point).
- Output: data_valid_o = FIFO non-empty; y0_o/y0z_o show the FIFO head.
  - Pop when data_valid_o & ready_i.
  - Head held stable while ready_i = 0.
- Push and pop in the same cycle on a full FIFO is legal; count unchanged.
- FIFO overflow is structurally impossible by the credit rule; verification asserts it.
- sof_o = 1 on the word with address 0; eof_o = 1 on the word with last_addr. Both are zero when data_valid_o = 0.
- DRAIN -> FIN when the eof word is accepted.
- FIN: done_o = 1 for one cycle, frame_cnt_o += 1 (not for the zero-bin case), busy_o <= 0, -> IDLE.
- Minimum latency: start_i at cycle 0 -> first data_valid_o at cycle 2+RdLatency (registered address, then RAM, then FIFO).
- Full throughput: one word per cycle while ready_i = 1.

Decomposition:
- Shared package holds SPEC_ADDR_W = 14, SPEC_POINT_BITS = 10, SPEC_MAX_BINS = 16, and the FSM state encoding (also used by SPEC_Acc-side control).
- One natural sub-module: spec_skid_fifo, a synchronous FIFO parameterised by width and depth with push/pop/count/empty/full.

Test Plan:
- nof_bins = 1, ready_i = 1, RAM holds data = addr: start -> 1024 words 0..1023 contiguous; sof on word 0, eof on 1023; done one cycle after eof accepted; frame_cnt 0 -> 1.
- nof_bins = 16, ready_i random 50%: 16384 words, exact order, no gaps or duplicates; y0 holds [15:0], y0z holds [31:16] of 0xABCD0000+addr.
- ready_i = 0 for 20 cycles mid-stream: rd_addr_o stalls once FIFO + inflight = 4; head word held; resumes with no loss. Repeat for RdLatency = 1, 2, 3.
- nof_bins = 0 -> done next cycle, no data_valid_o, frame_cnt unchanged; nof_bins = 20 -> 16384 words.
- start_i asserted again during a frame -> ignored; reset low at word 500 -> all outputs 0, next start reads from address 0, frame_cnt = 0.
